// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide sequencer.
//   md_op_t    : operation encoding as driven by the control unit
//   md_state_t : sequencer state encoding
//   MD_WIDTH   : default operand width
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} md_op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} md_state_t;

  // True for DIV/DIVU; selects the restoring-divide datapath.
  function automatic logic op_is_div(input md_op_t op);
    logic res;
    case (op)
      OP_DIV, OP_DIVU: res = 1'b1;
      default:         res = 1'b0;
    endcase
    return res;
  endfunction

  // True for MULT/DIV; operands are two's-complement and need sign handling.
  function automatic logic op_is_signed(input md_op_t op);
    logic res;
    case (op)
      OP_MULT, OP_DIV: res = 1'b1;
      default:         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide loop, purely combinational.
// Ports:
//   div_mode         : 1 = restoring divide step, 0 = shift-add multiply step
//   work_hi, work_lo : current working pair (accumulator / {rem, quot})
//   opd              : multiplicand (multiply) or divisor (divide) magnitude
//   next_hi, next_lo : working pair after this iteration
// Multiply keeps the multiplier in work_lo and shifts the product in from the
// top; divide shifts the dividend out of work_lo into the remainder.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] work_hi,
  input  logic [WIDTH-1:0] work_lo,
  input  logic [WIDTH-1:0] opd,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] diff_s;

  // Single add/shift or subtract/shift iteration.
  always_comb begin
    sum_s    = {1'b0, work_hi} + {1'b0, opd};
    rem_sh_s = {work_hi, work_lo[WIDTH-1]};
    // rem < divisor holds between steps, so the difference fits in WIDTH+1
    // signed bits and the top bit is a reliable "negative" flag.
    diff_s   = rem_sh_s - {1'b0, opd};
    next_hi  = work_hi;
    next_lo  = work_lo;
    if (div_mode) begin
      if (!diff_s[WIDTH]) begin
        next_hi = diff_s[WIDTH-1:0];
        next_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = rem_sh_s[WIDTH-1:0];
        next_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (work_lo[0]) begin
        // Carry out of the add re-enters as the new top bit after the shift.
        next_hi = sum_s[WIDTH:1];
        next_lo = {sum_s[0], work_lo[WIDTH-1:1]};
      end else begin
        next_hi = {1'b0, work_hi[WIDTH-1:1]};
        next_lo = {work_hi[0], work_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO result pair.
// Ports:
//   clk, rst     : clock; asynchronous active-low reset
//   start, op    : one-cycle request (sampled in IDLE) and operation
//   a, b         : rs / rt operands
//   busy         : sequencer not idle
//   done         : one-cycle pulse when hi/lo carry a new result
//   stall_req    : hold fetch (busy, or a request arriving while idle)
//   hi, lo       : product halves, or remainder / quotient
//   div_by_zero  : pulses with done when the finished divide had b == 0
// Flow: IDLE -(start)-> RUN for WIDTH iterations -> FIX (sign correction,
// result write) -> IDLE. Result latency is WIDTH+1 edges after start.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH-1);

  md_state_t        state_r, state_s;
  md_op_t           op_r;
  md_op_t           op_in_s;
  logic             sign_a_r, sign_b_r, b_zero_r;
  logic [WIDTH-1:0] a_raw_r;
  logic [WIDTH-1:0] opd_r;
  logic [WIDTH-1:0] work_hi_r, work_lo_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r, dbz_r;

  logic             in_signed_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH-1:0] step_hi_s, step_lo_s;
  logic [WIDTH-1:0] fix_hi_s, fix_lo_s;
  logic [2*WIDTH-1:0] prod_s;

  assign op_in_s     = md_op_t'(op);
  assign in_signed_s = op_is_signed(op_in_s);
  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude.
  assign a_mag_s     = (in_signed_s && a[WIDTH-1]) ? (~a + ONE_W) : a;
  assign b_mag_s     = (in_signed_s && b[WIDTH-1]) ? (~b + ONE_W) : b;
  assign prod_s      = {work_hi_r, work_lo_r};

  assign busy        = (state_r != S_IDLE);
  assign stall_req   = busy | (start & (state_r == S_IDLE));
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_mode (op_is_div(op_r)),
    .work_hi  (work_hi_r),
    .work_lo  (work_lo_r),
    .opd      (opd_r),
    .next_hi  (step_hi_s),
    .next_lo  (step_lo_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_RUN;
        else       state_s = S_IDLE;
      end
      S_RUN: begin
        if (cnt_r == {CNT_W{1'b0}}) state_s = S_FIX;
        else                        state_s = S_RUN;
      end
      S_FIX:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Sign correction and divide-by-zero override applied in FIX.
  always_comb begin
    fix_hi_s = work_hi_r;
    fix_lo_s = work_lo_r;
    if (op_is_div(op_r)) begin
      if (b_zero_r) begin
        fix_lo_s = {WIDTH{1'b1}};
        fix_hi_s = a_raw_r;
      end else begin
        // The -2^(W-1) / -1 case has equal signs, so the quotient magnitude
        // 0x80..0 passes through un-negated and wraps as required.
        if (sign_a_r ^ sign_b_r) fix_lo_s = ~work_lo_r + ONE_W;
        else                     fix_lo_s = work_lo_r;
        if (sign_a_r) fix_hi_s = ~work_hi_r + ONE_W;
        else          fix_hi_s = work_hi_r;
      end
    end else begin
      if (sign_a_r ^ sign_b_r) {fix_hi_s, fix_lo_s} = ~prod_s + ONE_2W;
      else                     {fix_hi_s, fix_lo_s} = prod_s;
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r      <= OP_MULT;
      sign_a_r  <= 1'b0;
      sign_b_r  <= 1'b0;
      b_zero_r  <= 1'b0;
      a_raw_r   <= {WIDTH{1'b0}};
      opd_r     <= {WIDTH{1'b0}};
      work_hi_r <= {WIDTH{1'b0}};
      work_lo_r <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      done_r    <= 1'b0;
      dbz_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            op_r      <= op_in_s;
            sign_a_r  <= in_signed_s & a[WIDTH-1];
            sign_b_r  <= in_signed_s & b[WIDTH-1];
            b_zero_r  <= (b == {WIDTH{1'b0}});
            a_raw_r   <= a;
            cnt_r     <= CNT_LOAD;
            work_hi_r <= {WIDTH{1'b0}};
            if (op_is_div(op_in_s)) begin
              work_lo_r <= a_mag_s;
              opd_r     <= b_mag_s;
            end else begin
              // Multiplier sits in the low half and is consumed LSB first.
              work_lo_r <= b_mag_s;
              opd_r     <= a_mag_s;
            end
          end
        end
        S_RUN: begin
          work_hi_r <= step_hi_s;
          work_lo_r <= step_lo_s;
          if (cnt_r != {CNT_W{1'b0}}) cnt_r <= cnt_r - CNT_ONE;
        end
        S_FIX: begin
          hi_r   <= fix_hi_s;
          lo_r   <= fix_lo_s;
          done_r <= 1'b1;
          dbz_r  <= op_is_div(op_r) & b_zero_r;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO result pair for MULT, MULTU, DIV and DIVU.
- The control unit issues a one-cycle start with the operation and the rs/rt operands (A_EX, readdata2_EX).
- The block runs a radix-2 shift-add or restoring-divide loop over WIDTH cycles and holds the fetch stage via stall_req.
- It then presents hi/lo, which feed the register-write mux for mfhi/mflo.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits
CNT_W, $clog2(WIDTH), width of the iteration counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset; asynchronous, active-low (asserted when 0)
start  input  1  operation request; sampled only in IDLE
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse when new hi/lo are valid
stall_req  output  1  combinational: busy OR (start AND state==IDLE)
hi  output  WIDTH  product[2W-1:W] or remainder
lo  output  WIDTH  product[W-1:0] or quotient
div_by_zero  output  1  registered with done; high if the completed divide had b==0

Behaviour:
- Reset (rst==0, any time, including mid-operation):
  - state=IDLE; hi, lo, counter and working registers cleared to 0.
  - busy, done and div_by_zero are 0.
  - Any in-flight operation is discarded.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - On edge E0 with start=1, latch op, sign flags and operand magnitudes.
  - Magnitudes are the two's-complement absolute value for signed ops; raw operands for unsigned ops.
  - Latch b_zero = (b==0); load counter = WIDTH-1; go to RUN.
  - start=0 in IDLE: no state change.
- RUN: one iteration per edge, WIDTH iterations total (edges E1..E_WIDTH); counter decrements each edge; leave for FIX when counter==0.
  - Multiply: 2W-bit accumulator; if multiplier LSB is 1, add multiplicand into the upper half; shift right 1 including carry.
  - Divide, restoring:
    - Shift {rem,quot} left 1.
    - Trial-subtract the divisor from rem (WIDTH+1-bit subtract).
    - If non-negative, keep the difference and set quot LSB to 1; otherwise restore.
- FIX: one edge (E_WIDTH+1). Apply sign correction, write hi/lo, pulse done=1, set div_by_zero=b_zero, go to IDLE.
  - MULT: negate the 2W-bit product when sign(a) != sign(b).
  - DIV: quotient negated when sign(a) != sign(b); remainder takes sign(a).
  - Overflow -2^(W-1) / -1 wraps: lo=0x80000000, hi=0.
  - DIV/DIVU with b_zero: override to lo=all ones, hi=a as latched (raw, unmodified); latency unchanged.
- Latency: done is high in the cycle after edge E_(WIDTH+1), i.e. WIDTH+1 edges after the start edge (33 for WIDTH=32). busy is high for exactly WIDTH+1 cycles.
- done, div_by_zero: single-cycle pulses; both return to 0 on the following edge unless a new completion occurs.
- hi/lo hold their value until the next FIX or reset. Reads during RUN return the previous result.
- start while busy: ignored; no queueing and no error.
- Back-to-back: in the done cycle state is already IDLE, so a start in that cycle is accepted.
- stall_req is high in the start cycle itself, so the instruction following mult/div is held without a bubble calculation in the CPU.
- op values are fully decoded; no illegal encodings exist.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} md_op_t
  - typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} md_state_t
  - localparam MD_WIDTH = 32
- One sub-module: muldiv_step, purely combinational.
  - Inputs: mode and current working registers.
  - Outputs: next working registers for one add/shift or subtract/shift iteration.
  - Keeps the FSM/counter logic in muldiv_seq separate from the arithmetic.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0.
- MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles; stall_req high from the start cycle.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100 b=7 -> lo=0x0000000E, hi=0x00000002.
- DIVU a=5 b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x00000005, div_by_zero=1 for one cycle; DIV a=0x80000000 b=-1 -> lo=0x80000000, hi=0.
- Start MULTU 6*7, pulse start again with other operands at cycle 10 -> second start ignored; result hi=0, lo=42. Start a new op in the done cycle -> accepted; its done follows 33 cycles later.
- Complete MULTU 2*3 (lo=6); start MULTU 9*9; drive rst=0 at cycle 15 -> busy=0, done=0, hi=lo=0 immediately (asynchronous, before the next clock edge) and no done pulse later. After release, a new MULTU 2*3 completes normally with lo=6.
